// File: rtl/fpnew_opgroup_out_fifo.sv
// Result buffer placed after an operation group. It stores result, status,
// extension bit and tag in a small FIFO and replays them in order. It cuts
// the combinational ready path and keeps sticky IEEE flags for every
// entry that downstream consumes.
module fpnew_opgroup_out_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 2,
    parameter type TagType = logic
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [Width-1:0]             in_result_i,
    input  logic [4:0]                   in_status_i,
    input  logic                         in_ext_bit_i,
    input  TagType                       in_tag_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic [Width-1:0]             out_result_o,
    output logic [4:0]                   out_status_o,
    output logic                         out_ext_bit_o,
    output TagType                       out_tag_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [4:0]                   fflags_o,
    input  logic                         fflags_clr_i,
    output logic [$clog2(Depth+1)-1:0]   usage_o,
    output logic                         busy_o
);

    // Depth outside 1..16 is a configuration error and stops elaboration.
    if (Depth == 0 || Depth > 16) begin : g_bad_depth
        $error("fpnew_opgroup_out_fifo: Depth must be within 1..16");
    end

    localparam int unsigned AddrW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned UsageW = $clog2(Depth + 1);

    localparam logic [AddrW-1:0]  LastIdx   = AddrW'(Depth - 1);
    localparam logic [UsageW-1:0] FullUsage = UsageW'(Depth);

    typedef struct packed {
        logic [Width-1:0] result;
        logic [4:0]       status;
        logic             ext_bit;
        TagType           tag;
    } entry_t;

    entry_t              mem [Depth];
    entry_t              head;
    logic [AddrW-1:0]    rd_ptr;
    logic [AddrW-1:0]    wr_ptr;
    logic [UsageW-1:0]   usage_q;
    logic [4:0]          fflags_q;
    logic                push;
    logic                pop;

    // Handshake: ready depends on stored state only, never on out_ready_i.
    assign in_ready_o  = (usage_q != FullUsage);
    assign out_valid_o = (usage_q != '0);
    assign busy_o      = (usage_q != '0);
    assign usage_o     = usage_q;

    assign push = in_valid_i & in_ready_o & ~flush_i;
    assign pop  = out_valid_o & out_ready_i;

    // Head entry is read straight from the register array, with no bypass path.
    assign head          = mem[rd_ptr];
    assign out_result_o  = head.result;
    assign out_status_o  = head.status;
    assign out_ext_bit_o = head.ext_bit;
    assign out_tag_o     = head.tag;
    assign fflags_o      = fflags_q;

    // Capture the incoming entry at the write pointer on every push.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the storage array is reset on purpose so an idle head reads
            // as all-zero; a plain FIFO would normally leave its memory unreset.
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= '{result: in_result_i, status: in_status_i,
                             ext_bit: in_ext_bit_i, tag: in_tag_i};
        end
    end

    // Advance the pointers and the occupancy count. Flush empties the FIFO at the next edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples the pre-edge values, whatever order the statements are in.
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            usage_q <= '0;
        end else if (flush_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            usage_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LastIdx) ? '0 : wr_ptr + AddrW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LastIdx) ? '0 : rd_ptr + AddrW'(1);
            end
            if (push && !pop) begin
                usage_q <= usage_q + UsageW'(1);
            end else if (pop && !push) begin
                usage_q <= usage_q - UsageW'(1);
            end
        end
    end

    // Sticky flags: apply the clear first, then OR in the status of any entry popped this cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= ({5{~fflags_clr_i}} & fflags_q) | ({5{pop}} & head.status);
        end
    end

endmodule

// File: tb/tb_fpnew_opgroup_out_fifo.sv
// Self-checking bench for fpnew_opgroup_out_fifo. A Depth=2 instance (a_*)
// covers the main features. A Depth=3 instance (b_*) covers pointer wrap
// and asynchronous reset. Expected behaviour comes from queue-based models.
module tb_fpnew_opgroup_out_fifo;

  typedef logic [7:0] tag_t;
  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  status;
    logic        ext_bit;
    tag_t        tag;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Depth-2 instance
  logic        a_flush = 0, a_in_valid = 0, a_in_ext = 0, a_out_ready = 0, a_clr = 0;
  logic [31:0] a_in_result = '0;
  logic [4:0]  a_in_status = '0;
  tag_t        a_in_tag = '0;
  logic        a_in_ready, a_out_valid, a_out_ext, a_busy;
  logic [31:0] a_out_result;
  logic [4:0]  a_out_status, a_fflags;
  tag_t        a_out_tag;
  logic [1:0]  a_usage;

  // Depth-3 instance
  logic        b_flush = 0, b_in_valid = 0, b_in_ext = 0, b_out_ready = 0, b_clr = 0;
  logic [31:0] b_in_result = '0;
  logic [4:0]  b_in_status = '0;
  tag_t        b_in_tag = '0;
  logic        b_in_ready, b_out_valid, b_out_ext, b_busy;
  logic [31:0] b_out_result;
  logic [4:0]  b_out_status, b_fflags;
  tag_t        b_out_tag;
  logic [1:0]  b_usage;

  fpnew_opgroup_out_fifo #(.Width(32), .Depth(2), .TagType(tag_t)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(a_flush),
    .in_result_i(a_in_result), .in_status_i(a_in_status), .in_ext_bit_i(a_in_ext),
    .in_tag_i(a_in_tag), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .out_result_o(a_out_result), .out_status_o(a_out_status), .out_ext_bit_o(a_out_ext),
    .out_tag_o(a_out_tag), .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .fflags_o(a_fflags), .fflags_clr_i(a_clr), .usage_o(a_usage), .busy_o(a_busy)
  );

  fpnew_opgroup_out_fifo #(.Width(32), .Depth(3), .TagType(tag_t)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(b_flush),
    .in_result_i(b_in_result), .in_status_i(b_in_status), .in_ext_bit_i(b_in_ext),
    .in_tag_i(b_in_tag), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .out_result_o(b_out_result), .out_status_o(b_out_status), .out_ext_bit_o(b_out_ext),
    .out_tag_o(b_out_tag), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .fflags_o(b_fflags), .fflags_clr_i(b_clr), .usage_o(b_usage), .busy_o(b_busy)
  );

  // Reference models: an ordered queue of stored entries plus the sticky flags.
  ent_t       qa[$];
  ent_t       qb[$];
  logic [4:0] fa = '0;
  logic [4:0] fb = '0;

  // One clock for instance a. The model advances from the inputs held across the edge.
  task automatic clock_a();
    bit   push, pop;
    ent_t e, d;
    push = a_in_valid && (qa.size() != 2) && !a_flush;
    pop  = (qa.size() != 0) && a_out_ready;
    e    = '{result: a_in_result, status: a_in_status, ext_bit: a_in_ext, tag: a_in_tag};
    @(posedge clk);
    if (a_clr) fa = '0;
    if (pop) begin
      d  = qa.pop_front();
      fa = fa | d.status;
    end
    if (a_flush) qa.delete();
    else if (push) qa.push_back(e);
    #1;
  endtask

  // One clock for instance b.
  task automatic clock_b();
    bit   push, pop;
    ent_t e, d;
    push = b_in_valid && (qb.size() != 3) && !b_flush;
    pop  = (qb.size() != 0) && b_out_ready;
    e    = '{result: b_in_result, status: b_in_status, ext_bit: b_in_ext, tag: b_in_tag};
    @(posedge clk);
    if (b_clr) fb = '0;
    if (pop) begin
      d  = qb.pop_front();
      fb = fb | d.status;
    end
    if (b_flush) qb.delete();
    else if (push) qb.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_a_in_ready: got %b want 1", a_in_ready); end
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_a_out_valid: got %b want 0", a_out_valid); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_a_busy: got %b want 0", a_busy); end
    total++; if (a_usage !== 2'd0) begin bad++; $display("FAIL reset_a_usage: got %0d want 0", a_usage); end
    total++; if (a_fflags !== 5'd0) begin bad++; $display("FAIL reset_a_fflags: got %b want 0", a_fflags); end
    total++; if ({a_out_result, a_out_status, a_out_ext, a_out_tag} !== 46'd0) begin
      bad++; $display("FAIL reset_a_data: got %h want 0", {a_out_result, a_out_status, a_out_ext, a_out_tag}); end
    total++; if ({b_in_ready, b_out_valid, b_busy, b_usage, b_fflags} !== 10'b10_0000_0000) begin
      bad++; $display("FAIL reset_b_ctrl: got %b want 1000000000", {b_in_ready, b_out_valid, b_busy, b_usage, b_fflags}); end
    total++; if ({b_out_result, b_out_status, b_out_ext, b_out_tag} !== 46'd0) begin
      bad++; $display("FAIL reset_b_data: got %h want 0", {b_out_result, b_out_status, b_out_ext, b_out_tag}); end
  endtask

  task automatic test_single_push();
    a_in_result = 32'h3F80_0000; a_in_status = 5'b00001; a_in_ext = 1'b1; a_in_tag = 8'd5;
    a_in_valid = 1'b1; a_out_ready = 1'b0;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL single_no_bypass: got %b want 0", a_out_valid); end
    clock_a();
    a_in_valid = 1'b0; a_in_result = $urandom; a_in_tag = 8'hFF;
    total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", a_out_valid); end
    total++; if (a_usage !== 2'd1) begin bad++; $display("FAIL single_usage: got %0d want 1", a_usage); end
    total++; if ({a_out_result, a_out_status, a_out_ext, a_out_tag} !== {32'h3F80_0000, 5'b00001, 1'b1, 8'd5}) begin
      bad++; $display("FAIL single_data: got %h want %h", {a_out_result, a_out_status, a_out_ext, a_out_tag},
                      {32'h3F80_0000, 5'b00001, 1'b1, 8'd5}); end
    clock_a();
    total++; if ({a_out_valid, a_out_result, a_out_status, a_out_ext, a_out_tag} !== {1'b1, 32'h3F80_0000, 5'b00001, 1'b1, 8'd5}) begin
      bad++; $display("FAIL single_stall_hold: got %h", {a_out_valid, a_out_result, a_out_status, a_out_ext, a_out_tag}); end
    a_out_ready = 1'b1;
    clock_a();
    a_out_ready = 1'b0;
    total++; if (a_fflags !== 5'b00001) begin bad++; $display("FAIL single_fflags: got %b want 00001", a_fflags); end
    total++; if (a_usage !== 2'd0) begin bad++; $display("FAIL single_usage_after_pop: got %0d want 0", a_usage); end
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL single_valid_after_pop: got %b want 0", a_out_valid); end
  endtask

  task automatic test_full();
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_tag = tag_t'(i); a_in_result = $urandom; a_in_status = 5'($urandom_range(0, 31)); a_in_ext = 1'($urandom);
      total++; if (a_in_ready !== (i < 2)) begin bad++; $display("FAIL full_in_ready_%0d: got %b want %b", i, a_in_ready, (i < 2)); end
      total++; if (a_usage !== 2'(i)) begin bad++; $display("FAIL full_usage_%0d: got %0d want %0d", i, a_usage, i); end
      clock_a();
    end
    total++; if ({a_in_ready, a_usage} !== 3'b0_10) begin bad++; $display("FAIL full_hold: got ready=%b usage=%0d want 0/2", a_in_ready, a_usage); end
    a_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++; if (a_out_valid !== 1'b1 || a_out_tag !== tag_t'(k)) begin
        bad++; $display("FAIL full_order_%0d: got valid=%b tag=%0d want 1/%0d", k, a_out_valid, a_out_tag, k); end
      total++; if (a_usage !== ((k == 0) ? 2'd2 : 2'd1)) begin
        bad++; $display("FAIL full_drain_usage_%0d: got %0d want %0d", k, a_usage, (k == 0) ? 2 : 1); end
      total++; if ({a_out_result, a_out_status, a_out_ext, a_out_tag} !== qa[0]) begin
        bad++; $display("FAIL full_data_%0d: got %h want %h", k, {a_out_result, a_out_status, a_out_ext, a_out_tag}, qa[0]); end
      if (k == 2) a_in_valid = 1'b0;
      clock_a();
    end
    a_out_ready = 1'b0;
    total++; if (a_usage !== 2'd0) begin bad++; $display("FAIL full_end_usage: got %0d want 0", a_usage); end
    total++; if (a_fflags !== fa) begin bad++; $display("FAIL full_fflags: got %b want %b", a_fflags, fa); end
  endtask

  task automatic test_back_to_back();
    a_in_valid = 1'b1; a_out_ready = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      if (k == 20) a_in_valid = 1'b0;
      a_in_tag = tag_t'(100 + k); a_in_result = $urandom; a_in_status = 5'($urandom_range(0, 31)); a_in_ext = 1'($urandom);
      if (k > 0) begin
        total++; if (a_out_valid !== 1'b1 || a_usage !== 2'd1 || a_in_ready !== 1'b1) begin
          bad++; $display("FAIL b2b_flow_%0d: got valid=%b usage=%0d ready=%b want 1/1/1", k, a_out_valid, a_usage, a_in_ready); end
        total++; if (a_out_tag !== tag_t'(100 + k - 1) || {a_out_result, a_out_status, a_out_ext, a_out_tag} !== qa[0]) begin
          bad++; $display("FAIL b2b_data_%0d: got %h want %h", k, {a_out_result, a_out_status, a_out_ext, a_out_tag}, qa[0]); end
      end
      clock_a();
    end
    a_out_ready = 1'b0;
    total++; if (a_usage !== 2'd0 || a_out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end: got usage=%0d valid=%b want 0/0", a_usage, a_out_valid); end
    total++; if (a_fflags !== fa) begin bad++; $display("FAIL b2b_fflags: got %b want %b", a_fflags, fa); end
  endtask

  task automatic test_clear_and_pop();
    a_clr = 1'b1; a_in_valid = 1'b1; a_in_status = 5'b00011; a_in_tag = 8'hA0; a_out_ready = 1'b0;
    clock_a();
    a_clr = 1'b0; a_in_status = 5'b10000; a_in_tag = 8'hA1;
    clock_a();
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    clock_a();
    total++; if (a_fflags !== 5'b00011) begin bad++; $display("FAIL clr_setup_fflags: got %b want 00011", a_fflags); end
    a_clr = 1'b1;
    total++; if (a_out_status !== 5'b10000) begin bad++; $display("FAIL clr_head_status: got %b want 10000", a_out_status); end
    clock_a();
    a_clr = 1'b0; a_out_ready = 1'b0;
    total++; if (a_fflags !== 5'b10000 || a_fflags !== fa) begin bad++; $display("FAIL clr_pop_fflags: got %b want 10000", a_fflags); end
  endtask

  task automatic test_flush();
    a_clr = 1'b1; clock_a(); a_clr = 1'b0;
    a_in_valid = 1'b1; a_in_status = 5'b00100; a_in_tag = 8'hB0; a_in_result = $urandom;
    clock_a();
    a_in_status = 5'b00000; a_in_tag = 8'hB1; a_in_result = $urandom;
    clock_a();
    total++; if (a_usage !== 2'd2) begin bad++; $display("FAIL flush_setup_usage: got %0d want 2", a_usage); end
    a_flush = 1'b1; a_out_ready = 1'b1; a_in_tag = 8'hEE;
    clock_a();
    a_flush = 1'b0; a_out_ready = 1'b0; a_in_valid = 1'b0;
    total++; if (a_usage !== 2'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_state: got usage=%0d valid=%b ready=%b want 0/0/1", a_usage, a_out_valid, a_in_ready); end
    total++; if (a_fflags !== 5'b00100) begin bad++; $display("FAIL flush_fflags: got %b want 00100", a_fflags); end
    clock_a();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_ghost: got %b want 0", a_out_valid); end
    // Flush while there is room: the same-cycle push must be dropped.
    a_in_valid = 1'b1; a_in_tag = 8'hC0; clock_a();
    total++; if (a_usage !== 2'd1) begin bad++; $display("FAIL flush2_setup: got %0d want 1", a_usage); end
    a_flush = 1'b1; a_in_tag = 8'hC1; clock_a();
    a_flush = 1'b0; a_in_valid = 1'b0;
    total++; if (a_usage !== 2'd0 || a_out_valid !== 1'b0) begin bad++; $display("FAIL flush2_drop: got usage=%0d valid=%b want 0/0", a_usage, a_out_valid); end
    clock_a();
    total++; if (a_out_valid !== 1'b0 || a_fflags !== fa) begin bad++; $display("FAIL flush2_after: got valid=%b fflags=%b want 0/%b", b_out_valid, a_fflags, fa); end
  endtask

  task automatic test_wrap_and_reset();
    logic [15:0] pat;
    int          nt;
    bit          acc;
    pat = 16'b1011_0101_1101_1000;
    nt  = 0;
    b_in_valid = 1'b1; b_in_tag = tag_t'(nt); b_in_result = $urandom; b_in_status = 5'($urandom_range(0, 31)); b_in_ext = 1'($urandom);
    for (int k = 0; k < 16; k++) begin
      b_out_ready = pat[k];
      total++; if (b_usage !== 2'(qb.size()) || b_in_ready !== (qb.size() != 3)) begin
        bad++; $display("FAIL wrap_ctrl_%0d: got usage=%0d ready=%b want %0d/%b", k, b_usage, b_in_ready, qb.size(), (qb.size() != 3)); end
      if (qb.size() != 0) begin
        total++; if (b_out_valid !== 1'b1 || {b_out_result, b_out_status, b_out_ext, b_out_tag} !== qb[0]) begin
          bad++; $display("FAIL wrap_data_%0d: got %h want %h", k, {b_out_result, b_out_status, b_out_ext, b_out_tag}, qb[0]); end
      end else begin
        total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL wrap_empty_%0d: got %b want 0", k, b_out_valid); end
      end
      acc = (qb.size() != 3);
      clock_b();
      if (acc) begin
        nt++;
        b_in_tag = tag_t'(nt); b_in_result = $urandom; b_in_status = 5'($urandom_range(0, 31)); b_in_ext = 1'($urandom);
      end
    end
    total++; if (nt < 7) begin bad++; $display("FAIL wrap_push_count: got %0d want >=7", nt); end
    total++; if (b_fflags !== fb) begin bad++; $display("FAIL wrap_fflags: got %b want %b", b_fflags, fb); end
    // Leave entries stored, then assert reset in the middle of a cycle.
    b_out_ready = 1'b0; b_in_valid = 1'b1;
    clock_b();
    b_in_valid = 1'b0;
    total++; if (b_usage !== 2'(qb.size()) || qb.size() == 0) begin
      bad++; $display("FAIL wrap_pre_reset: got usage=%0d want %0d (nonzero)", b_usage, qb.size()); end
    #2 rst = 1'b1;
    #1;
    total++; if (b_out_valid !== 1'b0 || b_usage !== 2'd0 || b_busy !== 1'b0) begin
      bad++; $display("FAIL async_reset: got valid=%b usage=%0d busy=%b want 0/0/0", b_out_valid, b_usage, b_busy); end
    total++; if (b_fflags !== 5'd0 || b_in_ready !== 1'b1) begin
      bad++; $display("FAIL async_reset_flags: got fflags=%b ready=%b want 0/1", b_fflags, b_in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    qa.delete(); qb.delete(); fa = '0; fb = '0;
    total++; if (b_out_valid !== 1'b0 || b_usage !== 2'd0) begin
      bad++; $display("FAIL post_reset: got valid=%b usage=%0d want 0/0", b_out_valid, b_usage); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_single_push();
    test_full();
    test_back_to_back();
    test_clear_and_pop();
    test_flush();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpnew_opgroup_out_fifo.md
# fpnew_opgroup_out_fifo

Result buffer placed directly downstream of an operation-group block. It accepts the group's result, status, extension bit and tag over a valid/ready handshake and stores them in a small FIFO. It replays them in order to the output arbiter while cutting the combinational ready path. It also accumulates sticky IEEE status flags for every result actually consumed.

## Interface
Parameters:
- Width, 32, result width in bits.
- Depth, 2, number of FIFO entries; legal range 1..16. Elaboration must fail outside this range.
- TagType, logic, type of the tag carried alongside each result.

Ports:
- Reset: one clock; reset is asynchronous and active-high.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous flush; discards all stored entries.
- in_result_i  in  Width  result from the upstream group.
- in_status_i  in  5  fpnew_pkg::status_t {NV,DZ,OF,UF,NX}.
- in_ext_bit_i  in  1  extension bit.
- in_tag_i  in  TagType  tag.
- in_valid_i  in  1  upstream valid.
- in_ready_o  out  1  FIFO can accept an entry.
- out_result_o  out  Width  head entry result.
- out_status_o  out  5  head entry status.
- out_ext_bit_o  out  1  head entry extension bit.
- out_tag_o  out  TagType  head entry tag.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream ready.
- fflags_o  out  5  sticky OR of the status of all popped entries.
- fflags_clr_i  in  1  clears fflags_o.
- usage_o  out  $clog2(Depth+1)  number of stored entries.
- busy_o  out  1  at least one entry is stored.

## Operation
- State: storage array[Depth], read pointer, write pointer, usage counter and the fflags register. There is no FSM beyond these counters.
- Push occurs when in_valid_i & in_ready_o & !flush_i. The entry is written at the write pointer; the write pointer increments and wraps from Depth-1 to 0.
- Pop occurs when out_valid_o & out_ready_i. The read pointer increments and wraps the same way.
- Usage after each cycle is usage + push − pop. A simultaneous push and pop leaves usage unchanged.
- in_ready_o = (usage != Depth). It depends only on state, never on out_ready_i. When full, a same-cycle pop does not enable a push.
- out_valid_o = (usage != 0). out_* present the entry at the read pointer.
- Output data may change only after a pop or after a push into an empty FIFO. A stalled head (valid & !ready) must hold all out_* stable.
- There is no bypass: an entry pushed into an empty FIFO is visible one cycle later.
- fflags_next = (fflags_clr_i ? 0 : fflags) | (pop ? out_status_o : 0). Clear is applied first, so a clear and a pop in the same cycle leaves exactly the popped status.
- Flush:
  - Pointers and usage go to 0 at the next edge.
  - A push in the flush cycle is dropped.
  - A pop in the flush cycle still ORs its status into fflags, because downstream consumed it.
  - fflags is not cleared by flush.
- busy_o = (usage != 0).

## Timing
- Reset values:
  - in_ready_o = 1 (with Depth ≥ 1).
  - out_valid_o = 0, busy_o = 0, usage_o = 0, fflags_o = 0.
  - All storage is zeroed, so out_result_o = 0, out_status_o = 0, out_ext_bit_o = 0 and out_tag_o = 0.
- Reset is asynchronous on assertion. Deassertion is treated as synchronous by the surrounding design.
- Reset asserted mid-stream discards all entries without any pop being counted.
- Latency from push edge to out_valid_o is 1 cycle.
- Throughput:
  - Depth ≥ 2 sustains one result per cycle under continuous out_ready_i.
  - Depth = 1 sustains one result every 2 cycles.
- Upstream must hold in_* stable while in_valid_i & !in_ready_o. The block does not depend on this, since it samples only on push.
- Wrap-around: with Depth = 3, the pointer sequence is 0,1,2,0. Ordering is preserved across the wrap.

## Test plan
- Reset then a single push (result 0x3F800000, status NX=1, tag 5) with out_ready_i=0 → the next cycle shows out_valid_o=1, usage_o=1 and data unchanged while stalled. Raising out_ready_i pops it, fflags_o=5'b00001 and usage_o=0.
- Depth=2, push 3 back-to-back with out_ready_i=0 → the third is refused (in_ready_o=0 at usage 2). Enabling out_ready_i yields tags 0,1 in order, then accepts the third.
- Depth=2, continuous in_valid_i and out_ready_i for 20 cycles with incrementing tags → 20 results out in order, 1 per cycle after the first, and usage_o stays at 1.
- Pop entry with status NV in the same cycle as fflags_clr_i=1 while fflags=5'b00011 → fflags_o becomes 5'b10000.
- usage=2 with flush_i=1, a pop of status OF and a push in the same cycle → usage_o=0, out_valid_o=0, fflags_o includes OF, and the pushed entry never appears.
- Depth=3, 7 push/pop cycles with irregular out_ready_i → order and data are intact across two pointer wraps. Asserting rst_i mid-stream gives out_valid_o=0 and usage_o=0 immediately, asynchronously.
